// File: rtl/ram_bus_master_pkg.sv
// Shared types and defaults for the TestRam bus master: FSM state encoding and width defaults.
package ram_bus_master_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned TIMEOUT_DEF    = 255;
  localparam int unsigned TIMER_WIDTH    = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_LO = 3'd1,
    ST_WAIT_LO  = 3'd2,
    ST_ISSUE_HI = 3'd3,
    ST_WAIT_HI  = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

endpackage

// File: rtl/ram_bus_master_if.sv
// CPU request/response and TestRam signals of the bus master, with both-side views.
interface ram_bus_master_if #(
  parameter int unsigned ADDR_WIDTH = ram_bus_master_pkg::ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = ram_bus_master_pkg::DATA_WIDTH_DEF
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic                    req_wide;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [2*DATA_WIDTH-1:0] rsp_rdata;
  logic                    rsp_err;

  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic                    ram_ready;

  modport master (
    input  req_valid, req_we, req_wide, req_addr, req_wdata, rsp_ready, ram_rdata, ram_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output req_valid, req_we, req_wide, req_addr, req_wdata, rsp_ready, ram_rdata, ram_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_bus_master_access_timer.sv
// Per-byte WAIT timer: 8-bit counter with clear/enable and a terminal-count flag.
module ram_bus_master_access_timer
  import ram_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [TIMER_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TIMER_WIDTH'(1);
    end
  end

  // High when one more enabled cycle brings the count to TIMEOUT_CYCLES.
  assign tc_c = (count == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ram_bus_master.sv
// TestRam initiator: turns byte/16-bit CPU requests into one or two byte accesses
// and returns a single response, aborting with rsp_err if data_ready never comes.
module ram_bus_master
  import ram_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst,
  ram_bus_master_if.master  bus
);

  localparam int unsigned RDW = 2 * DATA_WIDTH;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic                    wide_q, wide_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [RDW-1:0]          wdata_q, wdata_d;

  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [RDW-1:0]          rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;

  logic                    timer_clr;
  logic                    timer_en;
  logic                    timer_tc_c;

  ram_bus_master_access_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .tc_c (timer_tc_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      wide_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      wide_q      <= wide_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Next state and next register values; RAM drive changes on entry to an ISSUE state.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    wide_d      = wide_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d        = bus.req_we;
          wide_d      = bus.req_wide;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          ram_we_d    = bus.req_we;
          ram_addr_d  = bus.req_addr;
          ram_wdata_d = bus.req_wdata[DATA_WIDTH-1:0];
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = ST_ISSUE_LO;
        end
      end

      ST_ISSUE_LO: begin
        timer_clr = 1'b1;
        state_d   = ST_WAIT_LO;
      end

      ST_ISSUE_HI: begin
        timer_clr = 1'b1;
        state_d   = ST_WAIT_HI;
      end

      ST_WAIT_LO, ST_WAIT_HI: begin
        if (bus.ram_ready) begin
          ram_we_d = 1'b0;
          if (!we_q) begin
            if (state_q == ST_WAIT_HI) begin
              rsp_rdata_d[DATA_WIDTH +: DATA_WIDTH] = bus.ram_rdata;
            end else begin
              rsp_rdata_d[DATA_WIDTH-1:0] = bus.ram_rdata;
            end
          end
          if (state_q == ST_WAIT_LO && wide_q) begin
            // addr+1 wraps naturally at the address width.
            ram_addr_d  = addr_q + ADDR_WIDTH'(1);
            ram_wdata_d = wdata_q[DATA_WIDTH +: DATA_WIDTH];
            ram_we_d    = we_q;
            state_d     = ST_ISSUE_HI;
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end else begin
          timer_en = 1'b1;
          if (timer_tc_c) begin
            ram_we_d    = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: a behavioural TestRam plus a shadow byte memory that
// predicts every response.
module tb_ram_bus_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_bus_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  ram_bus_master #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit [7:0]    ram_mem   [65536];
  bit [7:0]    model_mem [65536];
  int unsigned cyc       = 0;
  int          ram_mode  = 1;  // 0 random stalls, 1 always ready, 2 single pulse at ready_at, 3 never
  int unsigned ready_at  = 0;
  logic        pre_en    = 1'b0;
  logic [15:0] pre_addr  = '0;
  logic [7:0]  pre_data  = '0;

  logic mon_wrap   = 1'b0;
  int   we_bad     = 0;
  int   wrap_bad   = 0;
  int   stable_bad = 0;
  int   rdy_bad    = 0;

  // Behavioural TestRam: registered data_out and data_ready.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) ram_mem[pre_addr] <= pre_data;
    else if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_addr];
    case (ram_mode)
      0:       bus.ram_ready <= ($urandom_range(0, 3) != 0);
      1:       bus.ram_ready <= 1'b1;
      2:       bus.ram_ready <= ((cyc + 1) == ready_at);
      default: bus.ram_ready <= 1'b0;
    endcase
  end

  // Protocol watchers.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.ram_we && (bus.rsp_valid || bus.req_ready)) we_bad <= we_bad + 1;
      if (mon_wrap && !bus.req_ready && bus.ram_addr !== 16'hFFFF && bus.ram_addr !== 16'h0000)
        wrap_bad <= wrap_bad + 1;
    end
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Drives one request, waits for its response; lat counts cycles with the accept cycle as 1.
  task automatic run_txn(input logic we, input logic wide, input logic [15:0] addr,
                         input logic [15:0] wdata, input int unsigned ready_after,
                         input int hold, input logic keep_valid,
                         output logic [15:0] rdata, output logic err, output int lat);
    int n;
    logic [15:0] r0;
    logic e0;
    lat = 0; rdata = '0; err = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_wide = wide;
    bus.req_addr = addr; bus.req_wdata = wdata;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (bus.req_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_wait: req_ready=%b required 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    if (ram_mode == 2) ready_at = cyc + ready_after;
    lat = 1;
    @(negedge clk);
    if (!keep_valid) bus.req_valid = 1'b0;
    lat = 2;
    while (bus.rsp_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
    if (bus.rsp_valid !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_wait: rsp_valid=%b required 1 within 400 cycles", bus.rsp_valid);
      lat = -1;
      return;
    end
    r0 = bus.rsp_rdata; e0 = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== r0 || bus.rsp_err !== e0) stable_bad++;
      if (bus.req_ready !== 1'b0) rdy_bad++;
    end
    bus.rsp_ready = 1'b1;
    rdata = bus.rsp_rdata; err = bus.rsp_err;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: we=%b addr=%h wdata=%h rsp_valid=%b rdata=%h err=%b required all 0",
               bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_req_ready: got %b required 0", bus.req_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++; $display("FAIL release_req_ready: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_read_byte();
    logic [15:0] r; logic e; int lat;
    ram_mode = 1;
    preload(16'h0010, 8'hA5);
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 0, 0, 1'b0, r, e, lat);
    n_cmp++;
    if (r !== 16'h00A5 || e !== 1'b0) begin
      n_bad++; $display("FAIL read_byte: rdata=%h err=%b required 00a5/0", r, e);
    end
    n_cmp++;
    if (lat !== 4) begin
      n_bad++; $display("FAIL read_byte_latency: got %0d required 4", lat);
    end
  endtask

  task automatic test_write_wide();
    logic [15:0] r; logic e; int lat;
    ram_mode = 1;
    run_txn(1'b1, 1'b1, 16'h1234, 16'hBEEF, 0, 0, 1'b0, r, e, lat);
    model_mem[16'h1234] = 8'hEF; model_mem[16'h1235] = 8'hBE;
    n_cmp++;
    if (lat !== 6 || r !== 16'h0000 || e !== 1'b0) begin
      n_bad++; $display("FAIL write_wide_rsp: lat=%0d rdata=%h err=%b required 6/0000/0", lat, r, e);
    end
    n_cmp++;
    if (ram_mem[16'h1234] !== 8'hEF || ram_mem[16'h1235] !== 8'hBE) begin
      n_bad++; $display("FAIL write_wide_mem: got %h %h required ef be", ram_mem[16'h1234], ram_mem[16'h1235]);
    end
    run_txn(1'b0, 1'b1, 16'h1234, 16'h0000, 0, 0, 1'b0, r, e, lat);
    n_cmp++;
    if (r !== 16'hBEEF || e !== 1'b0 || lat !== 6) begin
      n_bad++; $display("FAIL read_wide: rdata=%h err=%b lat=%0d required beef/0/6", r, e, lat);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] r; logic e; int lat; int snap;
    ram_mode = 0;
    snap = wrap_bad;
    mon_wrap = 1'b1;
    run_txn(1'b1, 1'b1, 16'hFFFF, 16'h5AC3, 0, 0, 1'b0, r, e, lat);
    mon_wrap = 1'b0;
    model_mem[16'hFFFF] = 8'hC3; model_mem[16'h0000] = 8'h5A;
    n_cmp++;
    if (ram_mem[16'hFFFF] !== 8'hC3 || ram_mem[16'h0000] !== 8'h5A) begin
      n_bad++; $display("FAIL wrap_mem: got %h %h required c3 5a", ram_mem[16'hFFFF], ram_mem[16'h0000]);
    end
    n_cmp++;
    if (wrap_bad !== snap) begin
      n_bad++; $display("FAIL wrap_addr: %0d cycles with ram_addr outside ffff/0000, required 0", wrap_bad - snap);
    end
    run_txn(1'b0, 1'b1, 16'hFFFF, 16'h0000, 0, 0, 1'b0, r, e, lat);
    n_cmp++;
    if (r !== 16'h5AC3 || e !== 1'b0) begin
      n_bad++; $display("FAIL wrap_read: rdata=%h err=%b required 5ac3/0", r, e);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] r; logic e; int lat;
    preload(16'h0040, 8'h77);
    preload(16'h0041, 8'h66);
    ram_mode = 3;
    run_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 0, 0, 1'b0, r, e, lat);
    n_cmp++;
    if (r !== 16'h0000 || e !== 1'b1 || lat !== 258) begin
      n_bad++; $display("FAIL timeout_byte: rdata=%h err=%b lat=%0d required 0000/1/258", r, e, lat);
    end
    run_txn(1'b0, 1'b1, 16'h0040, 16'h0000, 0, 0, 1'b0, r, e, lat);
    n_cmp++;
    if (r !== 16'h0000 || e !== 1'b1 || lat !== 258) begin
      n_bad++; $display("FAIL timeout_wide: rdata=%h err=%b lat=%0d required 0000/1/258", r, e, lat);
    end
    ram_mode = 2;
    run_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 256, 0, 1'b0, r, e, lat);
    n_cmp++;
    if (r !== 16'h0077 || e !== 1'b0 || lat !== 258) begin
      n_bad++; $display("FAIL ready_at_limit: rdata=%h err=%b lat=%0d required 0077/0/258", r, e, lat);
    end
    run_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 257, 0, 1'b0, r, e, lat);
    n_cmp++;
    if (r !== 16'h0000 || e !== 1'b1) begin
      n_bad++; $display("FAIL ready_past_limit: rdata=%h err=%b required 0000/1", r, e);
    end
    ram_mode = 1;
  endtask

  task automatic test_backpressure();
    logic [15:0] r; logic e; int lat; int s0; int q0;
    ram_mode = 1;
    preload(16'h0020, 8'h3C);
    preload(16'h0021, 8'h81);
    s0 = stable_bad; q0 = rdy_bad;
    run_txn(1'b0, 1'b1, 16'h0020, 16'h0000, 0, 10, 1'b1, r, e, lat);
    n_cmp++;
    if (r !== 16'h813C || e !== 1'b0) begin
      n_bad++; $display("FAIL backpressure_data: rdata=%h err=%b required 813c/0", r, e);
    end
    n_cmp++;
    if (stable_bad !== s0 || rdy_bad !== q0) begin
      n_bad++; $display("FAIL backpressure_hold: unstable=%0d req_ready_high=%0d required 0/0",
                        stable_bad - s0, rdy_bad - q0);
    end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++; $display("FAIL backpressure_reaccept: req_ready=%b required 1 after resp", bus.req_ready);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int n; int seen;
    ram_mode = 3;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_wide = 1'b0;
    bus.req_addr = 16'h3000; bus.req_wdata = 16'h0099;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.ram_we !== 1'b1) begin
      n_bad++; $display("FAIL midwrite_we: ram_we=%b required 1 before reset", bus.ram_we);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.ram_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      n_bad++; $display("FAIL midwrite_reset: we=%b rsp_valid=%b req_ready=%b required 0/0/0",
                        bus.ram_we, bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    ram_mode = 1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++; $display("FAIL midwrite_release: req_ready=%b required 1", bus.req_ready);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL midwrite_stale_rsp: rsp_valid high %0d cycles required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r; logic e; int lat;
    logic we; logic wide; logic [15:0] a; logic [15:0] wd; logic [15:0] exp_r; int w0;
    ram_mode = 0;
    w0 = we_bad;
    for (int t = 0; t < 40; t++) begin
      we   = 1'($urandom_range(0, 1));
      wide = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 7)) : 16'(16'hFFFC + $urandom_range(0, 3));
      wd   = 16'($urandom);
      if (we) exp_r = 16'h0000;
      else if (wide) exp_r = {model_mem[16'(a + 16'd1)], model_mem[a]};
      else exp_r = {8'h00, model_mem[a]};
      run_txn(we, wide, a, wd, 0, $urandom_range(0, 2), 1'b0, r, e, lat);
      if (we) begin
        model_mem[a] = wd[7:0];
        if (wide) model_mem[16'(a + 16'd1)] = wd[15:8];
      end
      n_cmp++;
      if (r !== exp_r || e !== 1'b0) begin
        n_bad++; $display("FAIL random_txn%0d: we=%b wide=%b addr=%h rdata=%h err=%b required %h/0",
                          t, we, wide, a, r, e, exp_r);
      end
    end
    n_cmp++;
    if (we_bad !== w0) begin
      n_bad++; $display("FAIL we_idle_resp: ram_we high in IDLE/RESP %0d times required 0", we_bad - w0);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_wide = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    bus.ram_rdata = '0; bus.ram_ready = 1'b0;
    test_reset();
    test_read_byte();
    test_write_wide();
    test_wrap();
    test_timeout();
    test_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
